// File: rtl/exec_scheduler.sv
// exec_scheduler: round-robin program sequencer for a single-core processor.
// Boots from BIOS, then time-slices between loaded program slots. It handles
// interrupts by requesting a context switch and running a BIOS service routine.
// Every output is a register that is loaded from the next-state decode.
module exec_scheduler #(
  parameter int NUM_PROG  = 4,
  parameter int QUANTUM_W = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        halt,
  input  logic [QUANTUM_W-1:0]        quantum,
  input  logic [NUM_PROG-1:0]         prog_valid,
  input  logic                        reload,
  input  logic                        irq,
  input  logic                        switch_ack,
  output logic                        exec_mi,
  output logic [$clog2(NUM_PROG)-1:0] prog_id,
  output logic                        switch_req,
  output logic                        irq_ack,
  output logic                        idle
);

  localparam int ID_W = $clog2(NUM_PROG);
  localparam logic [ID_W:0] NP_W = (ID_W+1)'(NUM_PROG);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_SELECT,
    ST_RUN,
    ST_SWITCH,
    ST_SERVICE,
    ST_IDLE
  } state_t;

  typedef enum logic {
    RSN_PREEMPT,
    RSN_IRQ
  } reason_t;

  state_t               state_reg, state_next;
  reason_t              reason_reg, reason_next;
  logic [NUM_PROG-1:0]  active_reg, active_next;
  logic [ID_W-1:0]      start_reg, start_next;
  logic [QUANTUM_W-1:0] counter_reg, counter_next;
  // Remembers whether the slice was loaded with a non-zero quantum, so a
  // quantum change mid-slice cannot enable or disable preemption early.
  logic                 preempt_en_reg, preempt_en_next;
  // Set when the service routine was entered from IDLE, so HALT returns there.
  logic                 from_idle_reg, from_idle_next;
  logic                 pending_reg, pending_next;
  logic                 irq_prev_reg;
  logic                 irq_rise;

  logic                 exec_mi_reg, exec_mi_next;
  logic [ID_W-1:0]      prog_id_reg, prog_id_next;
  logic                 switch_req_reg, switch_req_next;
  logic                 irq_ack_reg, irq_ack_next;
  logic                 idle_reg, idle_next;

  // Round-robin search: candidate slot for each offset from the search start
  logic [ID_W-1:0]      cand [NUM_PROG];
  logic [NUM_PROG-1:0]  hit;
  logic                 sel_found;
  logic [ID_W-1:0]      sel_slot;

  function automatic logic [ID_W-1:0] next_slot(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_PROG - 1)) begin
      return '0;
    end
    return id + ID_W'(1);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PROG; gi++) begin : g_scan
      logic [ID_W:0] sum_w;
      logic [ID_W:0] wrap_w;
      assign sum_w   = {1'b0, start_reg} + (ID_W+1)'(gi);
      assign wrap_w  = sum_w - NP_W;
      assign cand[gi] = (sum_w >= NP_W) ? wrap_w[ID_W-1:0] : sum_w[ID_W-1:0];
      assign hit[gi]  = active_reg[cand[gi]];
    end
  endgenerate

  // Priority pick: the lowest offset from the search start wins
  always_comb begin
    sel_found = 1'b0;
    sel_slot  = '0;
    for (int k = NUM_PROG - 1; k >= 0; k--) begin
      if (hit[k]) begin
        sel_found = 1'b1;
        sel_slot  = cand[k];
      end
    end
  end

  assign irq_rise = irq & ~irq_prev_reg;

  // Next-state, bookkeeping and registered-output decode
  always_comb begin
    state_next      = state_reg;
    reason_next     = reason_reg;
    active_next     = active_reg;
    start_next      = start_reg;
    counter_next    = counter_reg;
    preempt_en_next = preempt_en_reg;
    from_idle_next  = from_idle_reg;
    prog_id_next    = prog_id_reg;

    case (state_reg)
      ST_BOOT: begin
        if (halt) begin
          active_next = prog_valid;
          start_next  = '0;
          state_next  = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (sel_found) begin
          prog_id_next    = sel_slot;
          counter_next    = quantum;
          preempt_en_next = (quantum != '0);
          state_next      = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_RUN: begin
        // halt beats a pending irq, which beats quantum expiry
        if (halt) begin
          active_next[prog_id_reg] = 1'b0;
          start_next               = next_slot(prog_id_reg);
          state_next               = ST_SELECT;
        end else if (pending_reg) begin
          reason_next = RSN_IRQ;
          state_next  = ST_SWITCH;
        end else if (preempt_en_reg) begin
          counter_next = counter_reg - QUANTUM_W'(1);
          if (counter_reg == QUANTUM_W'(1)) begin
            reason_next = RSN_PREEMPT;
            state_next  = ST_SWITCH;
          end
        end
      end

      ST_SWITCH: begin
        if (switch_ack) begin
          if (reason_reg == RSN_IRQ) begin
            from_idle_next = 1'b0;
            state_next     = ST_SERVICE;
          end else begin
            start_next = next_slot(prog_id_reg);
            state_next = ST_SELECT;
          end
        end
      end

      ST_SERVICE: begin
        if (halt) begin
          if (from_idle_reg) begin
            state_next = ST_IDLE;
          end else begin
            counter_next    = quantum;
            preempt_en_next = (quantum != '0);
            state_next      = ST_RUN;
          end
        end
      end

      ST_IDLE: begin
        if (pending_reg) begin
          from_idle_next = 1'b1;
          state_next     = ST_SERVICE;
        end else if (reload) begin
          active_next = prog_valid;
          start_next  = '0;
          state_next  = ST_SELECT;
        end
      end

      default: begin
        state_next = ST_BOOT;
      end
    endcase

    exec_mi_next    = (state_next == ST_RUN);
    switch_req_next = (state_next == ST_SWITCH);
    irq_ack_next    = (state_next == ST_SERVICE) && (state_reg != ST_SERVICE);
    // While servicing an irq taken from IDLE there is still no program left
    idle_next       = (state_next == ST_IDLE) ||
                      ((state_next == ST_SERVICE) && from_idle_next);
    // A fresh edge arriving as the irq is taken stays pending
    pending_next    = (pending_reg & ~irq_ack_next) | irq_rise;
  end

  // State and output registers, cleared immediately by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_BOOT;
      reason_reg     <= RSN_PREEMPT;
      active_reg     <= '0;
      start_reg      <= '0;
      counter_reg    <= '0;
      preempt_en_reg <= 1'b0;
      from_idle_reg  <= 1'b0;
      pending_reg    <= 1'b0;
      irq_prev_reg   <= 1'b0;
      exec_mi_reg    <= 1'b0;
      prog_id_reg    <= '0;
      switch_req_reg <= 1'b0;
      irq_ack_reg    <= 1'b0;
      idle_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      reason_reg     <= reason_next;
      active_reg     <= active_next;
      start_reg      <= start_next;
      counter_reg    <= counter_next;
      preempt_en_reg <= preempt_en_next;
      from_idle_reg  <= from_idle_next;
      pending_reg    <= pending_next;
      irq_prev_reg   <= irq;
      exec_mi_reg    <= exec_mi_next;
      prog_id_reg    <= prog_id_next;
      switch_req_reg <= switch_req_next;
      irq_ack_reg    <= irq_ack_next;
      idle_reg       <= idle_next;
    end
  end

  assign exec_mi    = exec_mi_reg;
  assign prog_id    = prog_id_reg;
  assign switch_req = switch_req_reg;
  assign irq_ack    = irq_ack_reg;
  assign idle       = idle_reg;

endmodule

// File: tb/tb_exec_scheduler.sv
// Testbench for exec_scheduler: per-cycle vector tables checked through a
// scoreboard queue, plus hand-written reset sequences.
module tb_exec_scheduler;

  localparam int NP = 4;
  localparam int QW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          halt;
  logic          irq;
  logic          reload;
  logic          switch_ack;
  logic [QW-1:0] quantum;
  logic [NP-1:0] prog_valid;
  logic          exec_mi;
  logic [1:0]    prog_id;
  logic          switch_req;
  logic          irq_ack;
  logic          idle;

  exec_scheduler #(.NUM_PROG(NP), .QUANTUM_W(QW)) dut (
    .clock      (clock),
    .reset      (reset),
    .halt       (halt),
    .quantum    (quantum),
    .prog_valid (prog_valid),
    .reload     (reload),
    .irq        (irq),
    .switch_ack (switch_ack),
    .exec_mi    (exec_mi),
    .prog_id    (prog_id),
    .switch_req (switch_req),
    .irq_ack    (irq_ack),
    .idle       (idle)
  );

  always #5 clock = ~clock;

  // One clock cycle: inputs driven before the edge, outputs expected after it
  typedef struct {
    logic          halt;
    logic          irq;
    logic          reload;
    logic          ack;
    logic [NP-1:0] pv;
    logic [QW-1:0] q;
    logic [5:0]    want;   // {exec_mi, prog_id, switch_req, irq_ack, idle}
  } vec_t;

  vec_t       tbl[$];
  logic [5:0] sb_q[$];
  int         total  = 0;
  int         bad    = 0;
  int         vec_no = 0;

  task automatic row(input logic h, input logic i, input logic r, input logic a,
                     input logic [NP-1:0] pv, input int q,
                     input logic mi, input int id, input logic sw,
                     input logic ak, input logic idl);
    vec_t v;
    v.halt   = h;
    v.irq    = i;
    v.reload = r;
    v.ack    = a;
    v.pv     = pv;
    v.q      = QW'(q);
    v.want   = {mi, 2'(id), sw, ak, idl};
    tbl.push_back(v);
  endtask

  function automatic string fmt(input logic [5:0] o);
    return $sformatf("mi=%0b id=%0d sw=%0b ack=%0b idle=%0b",
                     o[5], o[4:3], o[2], o[1], o[0]);
  endfunction

  task automatic compare(input string name, input logic [5:0] want);
    logic [5:0] got;
    got = {exec_mi, prog_id, switch_req, irq_ack, idle};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(want));
    end
  endtask

  task automatic run_table();
    for (int n = 0; n < tbl.size(); n++) begin
      @(negedge clock);
      halt       = tbl[n].halt;
      irq        = tbl[n].irq;
      reload     = tbl[n].reload;
      switch_ack = tbl[n].ack;
      prog_valid = tbl[n].pv;
      quantum    = tbl[n].q;
      sb_q.push_back(tbl[n].want);
      @(posedge clock);
      #1;
      compare($sformatf("vec%0d", vec_no), sb_q.pop_front());
      $display("vec%0d h=%0b i=%0b r=%0b a=%0b pv=%b q=%0d -> %s",
               vec_no, tbl[n].halt, tbl[n].irq, tbl[n].reload, tbl[n].ack,
               tbl[n].pv, tbl[n].q, fmt({exec_mi, prog_id, switch_req, irq_ack, idle}));
      vec_no++;
    end
    tbl.delete();
  endtask

  task automatic apply_reset(input string name);
    @(negedge clock);
    halt = 1'b0; irq = 1'b0; reload = 1'b0; switch_ack = 1'b0;
    reset = 1'b0;
    #1;
    compare(name, 6'b0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; halt = 1'b0; irq = 1'b0; reload = 1'b0; switch_ack = 1'b0;
    quantum = '0; prog_valid = '0;
    #2 reset = 1'b0;
    #1 compare("reset_init", 6'b0);
    @(negedge clock);
    reset = 1'b1;

    // Boot, retire slots with wrap, IDLE, irq beats reload, reload restarts
    row(0,0,0,0, 4'b1010, 0,  0,0,0,0,0);  // BOOT waits for halt
    row(1,0,0,0, 4'b1010, 0,  0,0,0,0,0);  // -> SELECT
    row(0,0,0,0, 4'b1010, 0,  1,1,0,0,0);  // RUN slot 1
    row(0,0,0,0, 4'b1010, 0,  1,1,0,0,0);
    row(1,0,0,0, 4'b1010, 0,  0,1,0,0,0);  // retire slot 1
    row(0,0,0,0, 4'b1010, 0,  1,3,0,0,0);  // RUN slot 3
    row(1,0,0,0, 4'b1010, 0,  0,3,0,0,0);  // retire slot 3
    row(0,0,0,0, 4'b1010, 0,  0,3,0,0,1);  // nothing left -> IDLE
    row(0,1,0,0, 4'b1010, 0,  0,3,0,0,1);  // irq edge latched
    row(0,1,1,0, 4'b0100, 0,  0,3,0,1,1);  // irq wins over reload
    row(0,0,0,0, 4'b0100, 0,  0,3,0,0,1);  // SERVICE
    row(1,0,0,0, 4'b0100, 0,  0,3,0,0,1);  // halt -> back to IDLE
    row(0,0,1,0, 4'b0100, 0,  0,3,0,0,0);  // reload -> SELECT
    row(0,0,0,0, 4'b0100, 0,  1,2,0,0,0);  // RUN slot 2, no preemption
    // quantum raised mid-slice: slice loaded with 0 keeps running
    for (int k = 0; k < 8; k++) row(0,0,0,0, 4'b0100, 6,  1,2,0,0,0);
    // Interrupt in RUN with switch_ack after 5 cycles
    row(0,1,0,0, 4'b0100, 6,  1,2,0,0,0);  // edge latched
    row(0,1,0,0, 4'b0100, 6,  0,2,1,0,0);  // switch_req rises
    for (int k = 0; k < 4; k++) row(0,0,0,0, 4'b0100, 6,  0,2,1,0,0);
    row(0,0,0,1, 4'b0100, 6,  0,2,0,1,0);  // ack -> SERVICE, irq_ack pulse
    row(0,0,0,0, 4'b0100, 6,  0,2,0,0,0);
    row(1,0,0,0, 4'b0100, 6,  1,2,0,0,0);  // return to slot 2, counter = 6
    for (int k = 0; k < 5; k++) row(0,0,0,0, 4'b0100, 6,  1,2,0,0,0);
    row(0,0,0,0, 4'b0100, 6,  0,2,1,0,0);  // 6th RUN cycle expires
    row(0,0,0,1, 4'b0100, 6,  0,2,0,0,0);  // SELECT
    row(0,0,0,0, 4'b0100, 6,  1,2,0,0,0);  // single program reselected
    run_table();

    // Round-robin, quantum 3, switch_ack tied high
    apply_reset("reset_rr");
    row(1,0,0,1, 4'b1111, 3,  0,0,0,0,0);
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < 3; k++) row(0,0,0,1, 4'b1111, 3,  1,s%4,0,0,0);
      row(0,0,0,1, 4'b1111, 3,  0,s%4,1,0,0);
      row(0,0,0,1, 4'b1111, 3,  0,s%4,0,0,0);
    end
    run_table();

    // Collision: halt, pending irq and expiry in the same cycle
    apply_reset("reset_coll");
    row(1,0,0,1, 4'b0011, 2,  0,0,0,0,0);
    row(0,0,0,1, 4'b0011, 2,  1,0,0,0,0);  // RUN slot 0, counter 2
    row(0,1,0,1, 4'b0011, 2,  1,0,0,0,0);  // counter 1, irq latched
    row(1,1,0,1, 4'b0011, 2,  0,0,0,0,0);  // halt wins: slot 0 retired
    row(0,0,0,1, 4'b0011, 2,  1,1,0,0,0);  // RUN slot 1
    row(0,0,0,1, 4'b0011, 2,  0,1,1,0,0);  // irq still pending
    row(0,0,0,1, 4'b0011, 2,  0,1,0,1,0);  // serviced
    row(0,0,0,1, 4'b0011, 2,  0,1,0,0,0);
    row(1,0,0,1, 4'b0011, 2,  1,1,0,0,0);  // back on slot 1
    row(0,0,0,0, 4'b0011, 2,  1,1,0,0,0);
    row(0,0,0,0, 4'b0011, 2,  0,1,1,0,0);  // expiry -> SWITCH
    row(0,0,0,0, 4'b0011, 2,  0,1,1,0,0);  // waiting for switch_ack
    run_table();

    // Reset asserted mid-SWITCH while switch_ack is low
    #2 reset = 1'b0;
    #1 compare("reset_mid_switch", 6'b0);
    @(posedge clock);
    #1 compare("reset_held", 6'b0);
    @(negedge clock);
    reset = 1'b1;
    row(0,0,0,1, 4'b0011, 2,  0,0,0,0,0);  // BOOT ignores switch_ack
    row(1,0,0,0, 4'b0011, 2,  0,0,0,0,0);
    row(0,0,0,0, 4'b0011, 2,  1,0,0,0,0);  // mask reloaded from prog_valid
    run_table();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_scheduler.md
EXEC_SCHEDULER -- requirements
Module: exec_scheduler

Interface
REQ-001 SHALL have parameter NUM_PROG, default 4: number of program slots (2..16).
REQ-002 SHALL have parameter QUANTUM_W, default 8: width of the time-slice counter.
REQ-003 SHALL have port clock  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port halt  input  1  one-cycle pulse: the running code (BIOS, service routine or program) executed HALT.
REQ-006 SHALL have port quantum  input  QUANTUM_W  time slice in cycles; 0 disables preemption.
REQ-007 SHALL have port prog_valid  input  NUM_PROG  bit i = slot i holds a loaded program.
REQ-008 SHALL have port reload  input  1  pulse: re-arm the active mask from prog_valid.
REQ-009 SHALL have port irq  input  1  interrupt request; rising edge is latched.
REQ-010 SHALL have port switch_ack  input  1  processor has saved/restored context.
REQ-011 SHALL have port exec_mi  output  1  0 = fetch from BIOS, 1 = fetch from instruction memory.
REQ-012 SHALL have port prog_id  output  clog2(NUM_PROG)  slot currently selected.
REQ-013 SHALL have port switch_req  output  1  level request for a context switch.
REQ-014 SHALL have port irq_ack  output  1  one-cycle pulse when the interrupt is taken.
REQ-015 SHALL have port idle  output  1  no active program remains.

Function
REQ-016 SHALL implement states BOOT, SELECT, RUN, SWITCH, SERVICE, IDLE; all outputs registered.
REQ-017 BOOT: exec_mi=0; on halt load active mask = prog_valid, search start = slot 0, go SELECT.
REQ-018 SELECT (exactly one cycle): pick first set active bit scanning from search start upward, wrapping modulo NUM_PROG; found -> prog_id = slot, counter = quantum, go RUN; none -> go IDLE with idle=1.
REQ-019 RUN: exec_mi=1; counter decrements by 1 each cycle when quantum != 0.
REQ-020 RUN, halt: clear active bit of prog_id, search start = prog_id+1 (wrapped), go SELECT.
REQ-021 RUN, counter reaches 0 (quantum != 0): assert switch_req, go SWITCH with reason PREEMPT.
REQ-022 RUN, irq pending: assert switch_req, go SWITCH with reason IRQ.
REQ-023 Same-cycle priority in RUN: halt > irq pending > quantum expiry.
REQ-024 SWITCH: hold switch_req=1 until switch_ack=1; next cycle switch_req=0 and go SELECT (PREEMPT, start = prog_id+1) or SERVICE (IRQ).
REQ-025 Entering SERVICE: irq_ack pulses exactly one cycle, pending latch clears; exec_mi=0 in SERVICE.
REQ-026 SERVICE, halt: return to RUN on unchanged prog_id, counter reloaded from quantum; irq edges during SERVICE stay pending.
REQ-027 IDLE: exec_mi=0, idle=1; irq pending -> SERVICE (halt then returns to IDLE); reload -> active = prog_valid, start = 0, SELECT; irq wins over reload.
REQ-028 Preemption with a single active program reselects the same slot.
REQ-029 halt in SELECT or SWITCH SHALL be ignored.
REQ-030 quantum change mid-slice SHALL take effect only at next counter load.

Reset
REQ-031 reset low SHALL immediately force BOOT, exec_mi=0, prog_id=0, switch_req=0, irq_ack=0, idle=0, active=0, counter=0, pending=0, regardless of state.
REQ-032 reset asserted mid-SWITCH SHALL drop switch_req without waiting for switch_ack.

Verification
REQ-033 Boot: release reset, prog_valid=4'b1010, halt pulse -> exec_mi=1, prog_id=1 two cycles later.
REQ-034 Round-robin: quantum=3, prog_valid=4'b1111, switch_ack tied 1 -> prog_id sequence 0,1,2,3,0 with one switch_req per slice.
REQ-035 Completion: prog_valid=4'b0011, halt in each slot -> slot 0 then 1 cleared, idle=1; reload with prog_valid=4'b0100 -> prog_id=2.
REQ-036 Interrupt: irq edge in RUN on slot 2, switch_ack after 5 cycles -> switch_req high 5 cycles, irq_ack one pulse, exec_mi=0; halt -> RUN on slot 2, counter=quantum.
REQ-037 Collisions: halt, irq and expiry same cycle -> slot retired, irq still pending, serviced after next SELECT/RUN.
REQ-038 Reset mid-SWITCH with switch_ack=0 -> all outputs at reset values within same cycle, state BOOT.
